byte_pair_assembler: RTL and testbench

BYTE_PAIR_ASSEMBLER -- requirements
Module: byte_pair_assembler

---
 rtl/byte_asm_pkg.sv | 24 ++
 rtl/byte_pair_assembler_if.sv | 24 ++
 rtl/byte_asm_timer.sv | 29 ++
 rtl/byte_pair_assembler.sv | 88 ++++++++
 tb/tb_byte_pair_assembler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/byte_asm_pkg.sv
// rtl/byte_asm_pkg.sv - shared types, widths and byte packing; BYTE_ASM_BIGENDIAN_EN selects byte order
package byte_asm_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t S_LOW  = 2'd0;
    localparam state_t S_HIGH = 2'd1;
    localparam state_t S_FULL = 2'd2;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [BYTE_W-1:0] first,
        input logic [BYTE_W-1:0] second
    );
`ifdef BYTE_ASM_BIGENDIAN_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

endpackage

// File: rtl/byte_pair_assembler_if.sv
// rtl/byte_pair_assembler_if.sv - byte input, word output and status bundle
interface byte_pair_assembler_if;
    import byte_asm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              err_timeout;
    logic [15:0]       word_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_timeout, word_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err_timeout, word_count
    );

endinterface

// File: rtl/byte_asm_timer.sv
// rtl/byte_asm_timer.sv - second-byte wait counter; TIMEOUT_CYCLES = 0 never expires
module byte_asm_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + ONE;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/byte_pair_assembler.sv
// rtl/byte_pair_assembler.sv - assembles two bytes into a 16-bit word with second-byte timeout
module byte_pair_assembler
    import byte_asm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    byte_pair_assembler_if.slave  bus
);

    state_t            state_q;
    logic [BYTE_W-1:0] first_q;
    logic [WORD_W-1:0] word_q;
    logic [15:0]       count_q;
    logic              err_q;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;
    logic timer_clear;
    logic timer_enable;
    logic expired;

    assign in_ready  = !reset && (state_q != S_FULL);
    assign out_valid = !reset && (state_q == S_FULL);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;

    // A second byte on the expiry cycle suppresses the enable, so the byte wins.
    assign timer_clear  = (state_q != S_HIGH);
    assign timer_enable = (state_q == S_HIGH) && !in_fire;

    byte_asm_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOW;
            first_q <= '0;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= expired;
            if (out_fire) begin
                count_q <= count_q + 16'd1;
            end
            case (state_q)
                S_LOW: begin
                    if (in_fire) begin
                        first_q <= bus.in_data;
                        state_q <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (in_fire) begin
                        word_q  <= pack_word(first_q, bus.in_data);
                        state_q <= S_FULL;
                    end else if (expired) begin
                        state_q <= S_LOW;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_q <= S_LOW;
                    end
                end
                default: state_q <= S_LOW;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? word_q : '0;
    assign bus.err_timeout = err_q;
    assign bus.word_count  = count_q;

endmodule

// File: tb/tb_byte_pair_assembler.sv
// tb/tb_byte_pair_assembler.sv - directed self-checking bench for byte_pair_assembler
module tb_byte_pair_assembler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    byte_pair_assembler_if bus();

    byte_pair_assembler #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input logic [7:0] first, input logic [7:0] second);
`ifdef BYTE_ASM_BIGENDIAN_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

    task automatic send(input logic [7:0] b, input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        check({tag, "_rdy"}, 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_err", 32'(bus.err_timeout), 0);
        check("rst_wc", 32'(bus.word_count), 0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 32'(bus.in_ready), 1);

        // basic word, consumer always ready
        bus.out_ready = 1'b1;
        send(8'h7B, "t1a");
        send(8'h01, "t1b");
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_data", 32'(bus.out_data), 32'(exp_word(8'h7B, 8'h01)));
        step();
        check("t1_wc", 32'(bus.word_count), 1);
        check("t1_valid_after", 32'(bus.out_valid), 0);
        check("t1_data_zero", 32'(bus.out_data), 0);

        // backpressure: held word stays stable, extra byte is refused
        bus.out_ready = 1'b0;
        send(8'h34, "t2a");
        send(8'h12, "t2b");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_data", 32'(bus.out_data), 32'(exp_word(8'h34, 8'h12)));
            check("hold_rdy", 32'(bus.in_ready), 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        step();
        check("t2_wc", 32'(bus.word_count), 2);
        send(8'h56, "t2c");
        send(8'h78, "t2d");
        check("t2_next_data", 32'(bus.out_data), 32'(exp_word(8'h56, 8'h78)));
        step();
        check("t2_next_wc", 32'(bus.word_count), 3);

        // timeout after 16 idle cycles in S_HIGH
        send(8'hAA, "t3a");
        for (int i = 0; i < 15; i++) begin
            check("to_wait_err", 32'(bus.err_timeout), 0);
            check("to_wait_rdy", 32'(bus.in_ready), 1);
            step();
        end
        check("to_pre_err", 32'(bus.err_timeout), 0);
        step();
        check("to_pulse", 32'(bus.err_timeout), 1);
        check("to_valid", 32'(bus.out_valid), 0);
        step();
        check("to_pulse_end", 32'(bus.err_timeout), 0);
        send(8'h11, "t3b");
        send(8'h22, "t3c");
        check("to_next_data", 32'(bus.out_data), 32'(exp_word(8'h11, 8'h22)));
        step();
        check("to_next_wc", 32'(bus.word_count), 4);

        // second byte lands on the expiry cycle
        send(8'hCC, "t4a");
        for (int i = 0; i < 15; i++) begin
            step();
        end
        send(8'hDD, "t4b");
        check("race_err", 32'(bus.err_timeout), 0);
        check("race_valid", 32'(bus.out_valid), 1);
        check("race_data", 32'(bus.out_data), 32'(exp_word(8'hCC, 8'hDD)));
        step();
        check("race_err2", 32'(bus.err_timeout), 0);
        check("race_wc", 32'(bus.word_count), 5);

        // reset while waiting for the second byte
        send(8'h01, "t5a");
        reset = 1'b1;
        #1;
        check("rh_rdy", 32'(bus.in_ready), 0);
        step();
        check("rh_valid", 32'(bus.out_valid), 0);
        check("rh_data", 32'(bus.out_data), 0);
        check("rh_err", 32'(bus.err_timeout), 0);
        check("rh_wc", 32'(bus.word_count), 0);
        reset = 1'b0;
        step();
        check("rh_err_after", 32'(bus.err_timeout), 0);

        // reset while a word is held
        bus.out_ready = 1'b0;
        send(8'h5A, "t5b");
        send(8'hA5, "t5c");
        check("rf_valid_pre", 32'(bus.out_valid), 1);
        reset = 1'b1;
        #1;
        check("rf_valid", 32'(bus.out_valid), 0);
        check("rf_data", 32'(bus.out_data), 0);
        step();
        reset = 1'b0;
        #1;
        check("rf_rdy", 32'(bus.in_ready), 1);
        step();
        check("rf_err", 32'(bus.err_timeout), 0);
        check("rf_valid_after", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        send(8'h3C, "t5d");
        send(8'hC3, "t5e");
        check("rf_next_data", 32'(bus.out_data), 32'(exp_word(8'h3C, 8'hC3)));
        step();
        check("rf_next_wc", 32'(bus.word_count), 1);

        // streaming: three edges per word, word_count wraps after 65536 words
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5E;
        repeat (3 * 65534) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("wrap_ffff", 32'(bus.word_count), 32'h0000_FFFF);
        send(8'hE1, "t6a");
        send(8'h1E, "t6b");
        step();
        check("wrap_zero", 32'(bus.word_count), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
